acoustic_trigger_buffer: RTL and testbench



---
 rtl/acoustic_trigger_buffer_pkg.sv | 22 ++
 rtl/acoustic_trigger_buffer_ram.sv | 32 +++
 rtl/acoustic_trigger_buffer.sv | 155 +++++++++++++++
 tb/tb_acoustic_trigger_buffer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/acoustic_trigger_buffer_pkg.sv
// Shared types and constants for the acoustic trigger buffer.
package acoustic_pkg;

   localparam int unsigned NCHAN        = 4;
   localparam logic [13:0] ADC_MIDSCALE = 14'd8192;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_ARMED,
      S_POST,
      S_READ
   } state_t;

   typedef enum logic [1:0] {
      CH_A = 2'd0,
      CH_B = 2'd1,
      CH_C = 2'd2,
      CH_D = 2'd3
   } chan_t;

endpackage

// File: rtl/acoustic_trigger_buffer_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port (latency 1).
module sample_ram #(
   parameter  int unsigned DEPTH = 1024,
   parameter  int unsigned WIDTH = 56,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_re,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // Output register only advances on a read, so it doubles as the stall hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       r_q <= '0;
      else if (i_re) r_q <= r_mem[i_raddr];
   end

   assign o_rdata = r_q;

endmodule

// File: rtl/acoustic_trigger_buffer.sv
// Pre/post-trigger capture ring for four hydrophone channels, streamed oldest-first.
// Optional macro ACOUSTIC_FORCE_TRIG_EN adds the force_trig input.
module acoustic_trigger_buffer
   import acoustic_pkg::*;
#(
   parameter int unsigned DATA_W    = 14,
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned PRE_DEPTH = 256
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_W-1:0]       din_a,
   input  logic [DATA_W-1:0]       din_b,
   input  logic [DATA_W-1:0]       din_c,
   input  logic [DATA_W-1:0]       din_d,
   input  logic                    din_valid,
   input  logic                    arm,
   input  logic [DATA_W-1:0]       threshold,
   input  logic [1:0]              trig_chan,
`ifdef ACOUSTIC_FORCE_TRIG_EN
   input  logic                    force_trig,
`endif
   output logic [NCHAN*DATA_W-1:0] rd_data,
   output logic                    rd_valid,
   input  logic                    rd_ready,
   output logic                    busy,
   output logic                    trig_seen,
   output logic                    done
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned WW = NCHAN * DATA_W;
   localparam logic [DATA_W-1:0] MID       = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [AW-1:0]     PRE_OFF   = AW'(PRE_DEPTH);
   localparam logic [CW-1:0]     POST_INIT = CW'(DEPTH - PRE_DEPTH - 1);

   state_t            r_state, w_next;
   logic [AW-1:0]     r_wr_ptr, r_rd_addr;
   logic [CW-1:0]     r_fill_cnt, r_post_cnt, r_issue_cnt, r_out_cnt;
   logic              r_rd_valid, r_trig_seen;
   logic [DATA_W-1:0] w_sel, w_mag;
   logic              w_hit, w_trig, w_we, w_re, w_xfer, w_last;

   always_comb begin
      w_sel = din_a;
      case (chan_t'(trig_chan))
         CH_A:    w_sel = din_a;
         CH_B:    w_sel = din_b;
         CH_C:    w_sel = din_c;
         CH_D:    w_sel = din_d;
         default: w_sel = din_a;
      endcase
   end

   assign w_mag = w_sel[DATA_W-1] ? (w_sel - MID) : (MID - w_sel);
`ifdef ACOUSTIC_FORCE_TRIG_EN
   assign w_hit = (w_mag > threshold) || force_trig;
`else
   assign w_hit = (w_mag > threshold);
`endif
   assign w_trig = (r_state == S_ARMED) && din_valid && w_hit;
   assign w_xfer = r_rd_valid && rd_ready;
   assign w_last = (r_out_cnt == CW'(DEPTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // r_post_cnt holds the number of post-trigger writes still to come.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (arm) w_next = S_FILL;
         S_FILL:  if (din_valid && r_fill_cnt == CW'(PRE_DEPTH - 1)) w_next = S_ARMED;
         S_ARMED: if (w_trig) w_next = (POST_INIT == '0) ? S_READ : S_POST;
         S_POST:  if (din_valid && r_post_cnt == CW'(1)) w_next = S_READ;
         S_READ:  if (w_xfer && w_last) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      w_we = 1'b0;
      w_re = 1'b0;
      done = 1'b0;
      case (r_state)
         S_FILL, S_ARMED, S_POST: begin
            busy = 1'b1;
            w_we = din_valid;
         end
         S_READ: begin
            busy = 1'b1;
            w_re = (!r_rd_valid || rd_ready) && (r_issue_cnt != CW'(DEPTH));
            done = w_xfer && w_last;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_addr   <= '0;
         r_fill_cnt  <= '0;
         r_post_cnt  <= '0;
         r_issue_cnt <= '0;
         r_out_cnt   <= '0;
         r_rd_valid  <= 1'b0;
         r_trig_seen <= 1'b0;
      end else begin
         r_trig_seen <= w_trig;
         if (r_state == S_IDLE && arm) begin
            r_wr_ptr    <= '0;
            r_fill_cnt  <= '0;
            r_post_cnt  <= '0;
            r_issue_cnt <= '0;
            r_out_cnt   <= '0;
         end
         if (w_we) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (r_state == S_FILL && din_valid) r_fill_cnt <= r_fill_cnt + CW'(1);
         if (w_trig) begin
            r_rd_addr  <= r_wr_ptr - PRE_OFF;
            r_post_cnt <= POST_INIT;
         end
         if (r_state == S_POST && din_valid) r_post_cnt <= r_post_cnt - CW'(1);
         if (w_re) begin
            r_rd_addr   <= r_rd_addr + AW'(1);
            r_issue_cnt <= r_issue_cnt + CW'(1);
         end
         if (!r_rd_valid || rd_ready) r_rd_valid <= w_re;
         if (w_xfer) r_out_cnt <= r_out_cnt + CW'(1);
      end
   end

   sample_ram #(
      .DEPTH (DEPTH),
      .WIDTH (WW)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_we),
      .i_waddr (r_wr_ptr),
      .i_wdata ({din_d, din_c, din_b, din_a}),
      .i_re    (w_re),
      .i_raddr (r_rd_addr),
      .o_rdata (rd_data)
   );

   assign rd_valid  = r_rd_valid;
   assign trig_seen = r_trig_seen;

endmodule

// File: tb/tb_acoustic_trigger_buffer.sv
// Bench for acoustic_trigger_buffer: frame-list reference model with directed and random acquisitions.
module tb_acoustic_trigger_buffer;
   import acoustic_pkg::*;

   localparam int DW    = 14;
   localparam int DEPTH = 16;
   localparam int PRE   = 4;
   localparam int NF    = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] din_a, din_b, din_c, din_d, threshold;
   logic          din_valid, arm, rd_ready, rd_valid, busy, trig_seen, done;
   logic [1:0]    trig_chan;
   logic [4*DW-1:0] rd_data;
   logic          force_trig;

   int n_checks = 0;
   int n_errors = 0;

   logic [DW-1:0] fr [NF][4];
   bit            ff [NF];

   always #5 clk = ~clk;

   acoustic_trigger_buffer #(
      .DATA_W    (DW),
      .DEPTH     (DEPTH),
      .PRE_DEPTH (PRE)
   ) dut (
`ifdef ACOUSTIC_FORCE_TRIG_EN
      .force_trig (force_trig),
`endif
      .clk        (clk),
      .rst        (rst),
      .din_a      (din_a),
      .din_b      (din_b),
      .din_c      (din_c),
      .din_d      (din_d),
      .din_valid  (din_valid),
      .arm        (arm),
      .threshold  (threshold),
      .trig_chan  (trig_chan),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .rd_ready   (rd_ready),
      .busy       (busy),
      .trig_seen  (trig_seen),
      .done       (done)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int mag(input logic [DW-1:0] s);
      int m;
      m = int'(s) - int'(ADC_MIDSCALE);
      return (m < 0) ? -m : m;
   endfunction

   // First frame past the pre-trigger fill whose selected channel exceeds the threshold.
   function automatic int find_trig(input int thr, input int ch);
      for (int k = PRE; k < NF; k++)
         if (mag(fr[k][ch]) > thr || ff[k]) return k;
      return -1;
   endfunction

   task automatic fill_ramp();
      for (int k = 0; k < NF; k++) begin
         fr[k][0] = 14'(int'(ADC_MIDSCALE) + k);
         fr[k][1] = ADC_MIDSCALE;
         fr[k][2] = ADC_MIDSCALE;
         fr[k][3] = ADC_MIDSCALE;
         ff[k]    = 1'b0;
      end
   endtask

   task automatic send_frame(input int k, input bit exp_trig);
      int gap;
      din_a = fr[k][0]; din_b = fr[k][1]; din_c = fr[k][2]; din_d = fr[k][3];
      force_trig = ff[k];
      din_valid  = 1'b1;
      @(posedge clk); #1;
      din_valid  = 1'b0;
      force_trig = 1'b0;
      chk("trig_seen", trig_seen, exp_trig);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
         @(posedge clk); #1;
         chk("trig_idle", trig_seen, 1'b0);
      end
   endtask

   task automatic read_window(input int t, input int mode);
      int idx = 0, cyc = 0, first = -1, last = 0;
      bit prev_stall = 1'b0;
      logic [4*DW-1:0] prev_data = '0, exp;
      while (idx < DEPTH && cyc < 500) begin
         case (mode)
            0:       rd_ready = 1'b1;
            1:       rd_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: rd_ready = 1'($urandom_range(0, 1));
         endcase
         #1;
         if (prev_stall) begin
            chk("hold_valid", rd_valid, 1'b1);
            chk("hold_data", rd_data, prev_data);
         end
         if (rd_valid && rd_ready) begin
            exp = {fr[t-PRE+idx][3], fr[t-PRE+idx][2], fr[t-PRE+idx][1], fr[t-PRE+idx][0]};
            chk("rd_data", rd_data, exp);
            chk("done", done, idx == DEPTH - 1);
            if (first < 0) first = cyc;
            last = cyc;
            idx++;
         end else begin
            chk("done_idle", done, 1'b0);
         end
         prev_stall = rd_valid && !rd_ready;
         prev_data  = rd_data;
         @(posedge clk); #1;
         cyc++;
      end
      if (idx < DEPTH) chk("read_timeout", idx, DEPTH);
      if (mode == 0) chk("throughput", last - first, DEPTH - 1);
      chk("busy_end", busy, 1'b0);
      chk("rd_valid_end", rd_valid, 1'b0);
      rd_ready = 1'b0;
   endtask

   task automatic acquire(input int thr, input int ch, input int mode, input int abort_post);
      int t;
      t = find_trig(thr, ch);
      if (t < 0) begin
         $display("FAIL model_setup no trigger frame");
         $fatal(1);
      end
      threshold = 14'(thr);
      trig_chan = 2'(ch);
      // A frame strobed together with arm must not land in the window.
      arm = 1'b1; din_valid = 1'b1;
      din_a = 14'h3FFF; din_b = 14'h3FFF; din_c = 14'h3FFF; din_d = 14'h3FFF;
      @(posedge clk); #1;
      arm = 1'b0; din_valid = 1'b0;
      chk("busy_arm", busy, 1'b1);
      for (int k = 0; k <= t + DEPTH - PRE - 1; k++) begin
         send_frame(k, k == t);
         if (abort_post >= 0 && k == t + abort_post) begin
            #2 rst = 1'b1;
            #1;
            chk("rst_busy", busy, 1'b0);
            chk("rst_rd_valid", rd_valid, 1'b0);
            @(posedge clk); #1;
            rst = 1'b0;
            return;
         end
      end
      chk("busy_read", busy, 1'b1);
      repeat (2) send_frame(0, 1'b0);
      read_window(t, mode);
   endtask

   initial begin
      rst = 1'b1; arm = 1'b0; din_valid = 1'b0; rd_ready = 1'b0; force_trig = 1'b0;
      din_a = '0; din_b = '0; din_c = '0; din_d = '0; threshold = '0; trig_chan = '0;
      #3;
      chk("rst_busy0", busy, 1'b0);
      chk("rst_valid0", rd_valid, 1'b0);
      chk("rst_done0", done, 1'b0);
      chk("rst_trig0", trig_seen, 1'b0);
      chk("rst_data0", rd_data, '0);
      @(posedge clk); #1;
      rst = 1'b0;

      fill_ramp(); fr[9][0] = 14'd12000;
      acquire(1000, 0, 0, -1);

      acquire(1000, 0, 0, 3);
      acquire(1000, 0, 2, -1);

      fill_ramp();
      for (int k = 0; k < 4; k++) fr[k][0] = 14'd12000;
      fr[7][0] = 14'd12000;
      acquire(1000, 0, 1, -1);

      fill_ramp(); fr[18][0] = 14'd12000;
      acquire(1000, 0, 2, -1);

      fill_ramp(); fr[8][1] = 14'd8191;
      acquire(0, 1, 0, -1);

      fill_ramp(); fr[7][2] = 14'd16382; fr[10][2] = 14'd16383;
      acquire(8190, 2, 1, -1);

`ifdef ACOUSTIC_FORCE_TRIG_EN
      fill_ramp(); ff[6] = 1'b1;
      acquire(100, 0, 0, -1);
`endif

      for (int r = 0; r < 4; r++) begin
         int ch, thr;
         ch  = $urandom_range(0, 3);
         thr = $urandom_range(500, 4000);
         for (int k = 0; k < NF; k++) begin
            ff[k] = 1'b0;
            for (int c = 0; c < 4; c++) begin
               int off;
               off = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 8191) : $urandom_range(0, thr);
               fr[k][c] = ($urandom_range(0, 1) == 1) ? 14'(8192 + off) : 14'(8192 - off);
            end
         end
         fr[30][ch] = '0;
         acquire(thr, ch, r % 3, -1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
